// File: rtl/hazard_pkg.sv
// Shared opcode map, operand use classes and width helper for the hazard scoreboard.
package hazard_pkg;

    localparam logic [3:0] OPC_LW  = 4'b1000;
    localparam logic [3:0] OPC_SW  = 4'b1001;
    localparam logic [3:0] OPC_LLB = 4'b1010;
    localparam logic [3:0] OPC_LHB = 4'b1011;
    localparam logic [3:0] OPC_B   = 4'b1100;
    localparam logic [3:0] OPC_BR  = 4'b1101;
    localparam logic [3:0] OPC_PCS = 4'b1110;
    localparam logic [3:0] OPC_HLT = 4'b1111;

    // Pipeline stage in which a source operand is consumed.
    typedef enum logic [1:0] {
        USE_NONE = 2'd0,
        USE_EX   = 2'd1,
        USE_MEM  = 2'd2,
        USE_ID   = 2'd3
    } use_e;

    // Ceiling log2, never less than 1 so it is always a legal vector width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Opcode classifier: which registers an instruction writes and where it reads them.
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       writes_rd,
    output logic       is_load,
    output logic       is_branch,
    output use_e       rs_use,
    output use_e       rt_use
);

    always_comb begin
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        rs_use    = USE_NONE;
        rt_use    = USE_NONE;
        if (!opcode[3]) begin
            writes_rd = 1'b1;
            rs_use    = USE_EX;
            rt_use    = USE_EX;
        end else begin
            case (opcode)
                OPC_LW: begin
                    writes_rd = 1'b1;
                    is_load   = 1'b1;
                    rs_use    = USE_EX;
                end
                OPC_SW: begin
                    rs_use = USE_EX;
                    rt_use = USE_MEM;
                end
                // Byte loads merge into the old rd value, which arrives on rs.
                OPC_LLB, OPC_LHB: begin
                    writes_rd = 1'b1;
                    rs_use    = USE_EX;
                end
                OPC_PCS: writes_rd = 1'b1;
                OPC_B:   is_branch = 1'b1;
                OPC_BR: begin
                    is_branch = 1'b1;
                    rs_use    = USE_ID;
                end
                OPC_HLT: ;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard driving stall, bubble and flush for the ID stage,
// plus a saturating count of bubble cycles.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned REG_W     = 4,
    parameter int unsigned ALU_LAT   = 2,
    parameter int unsigned LOAD_LAT  = 3,
    parameter int unsigned EX_SLACK  = 2,
    parameter int unsigned MEM_SLACK = 3,
    parameter int unsigned PERF_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [INSTR_W-1:0]      id_instr,
    input  logic [REG_W-1:0]        ID_rs,
    input  logic [REG_W-1:0]        ID_rt,
    input  logic [REG_W-1:0]        ID_rd,
    input  logic                    mem_stall,
    input  logic                    branch_taken,
    output logic                    stall,
    output logic                    bubble,
    output logic                    flush,
    output logic [(1<<REG_W)-1:0]   busy_mask,
    output logic [PERF_W-1:0]       hazard_cnt
);

    localparam int unsigned NUM_REGS = 1 << REG_W;
    localparam int unsigned CNT_W    = clog2(LOAD_LAT + 1);

    logic             writes_rd;
    logic             is_load;
    logic             is_branch;
    use_e             rs_use;
    use_e             rt_use;
    logic             hazard;
    logic             issue;
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic             unused_instr_bits;

    assign unused_instr_bits = ^id_instr[INSTR_W-5:0];

    hazard_decode u_decode (
        .opcode    (id_instr[INSTR_W-1 -: 4]),
        .writes_rd (writes_rd),
        .is_load   (is_load),
        .is_branch (is_branch),
        .rs_use    (rs_use),
        .rt_use    (rt_use)
    );

    // Largest countdown a source can still carry and be forwarded in time.
    function automatic int unsigned slack_of(input use_e u);
        case (u)
            USE_EX:  return EX_SLACK;
            USE_MEM: return MEM_SLACK;
            default: return 0;
        endcase
    endfunction

    function automatic logic src_hazard(input use_e u, input logic [REG_W-1:0] r,
                                        input logic [CNT_W-1:0] c);
        return (u != USE_NONE) && (r != '0) && (32'(c) > slack_of(u));
    endfunction

    always_comb begin
        hazard = id_valid && (src_hazard(rs_use, ID_rs, cnt[ID_rs]) ||
                              src_hazard(rt_use, ID_rt, cnt[ID_rt]));
        issue  = id_valid && !hazard && !mem_stall;
        stall  = hazard;
        bubble = hazard && !mem_stall;
        flush  = issue && is_branch && branch_taken;
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    // A fresh issue to a register overrides its running countdown; mem_stall freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            hazard_cnt <= '0;
        end else if (!mem_stall) begin
            cnt[0] <= '0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (issue && writes_rd && (ID_rd == REG_W'(r))) begin
                    cnt[r] <= is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            if (bubble && (hazard_cnt != '1)) begin
                hazard_cnt <= hazard_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard: stall latencies, freeze, overlap, reset, saturation.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam logic [3:0] OPC_ADD = 4'b0000;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [3:0]  ID_rs;
    logic [3:0]  ID_rt;
    logic [3:0]  ID_rd;
    logic        mem_stall;
    logic        branch_taken;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [15:0] busy_mask;
    logic [15:0] hazard_cnt;
    logic        stall_s;
    logic        bubble_s;
    logic        flush_s;
    logic [15:0] busy_mask_s;
    logic [1:0]  hc_sat;

    int vectors;
    int miscompares;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd), .mem_stall(mem_stall),
        .branch_taken(branch_taken), .stall(stall), .bubble(bubble), .flush(flush),
        .busy_mask(busy_mask), .hazard_cnt(hazard_cnt)
    );

    hazard_scoreboard #(.PERF_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd), .mem_stall(mem_stall),
        .branch_taken(branch_taken), .stall(stall_s), .bubble(bubble_s), .flush(flush_s),
        .busy_mask(busy_mask_s), .hazard_cnt(hc_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic s, input logic b, input logic f);
        chk({tag, "_stall"},  32'(stall),  32'(s));
        chk({tag, "_bubble"}, 32'(bubble), 32'(b));
        chk({tag, "_flush"},  32'(flush),  32'(f));
    endtask

    task automatic chk_busy(input string tag, input logic [15:0] exp);
        chk(tag, 32'(busy_mask), 32'(exp));
    endtask

    task automatic chk_hc(input string tag, input int exp);
        chk(tag, 32'(hazard_cnt), 32'(exp));
        chk({tag, "_sat"}, 32'(hc_sat), 32'((exp > 3) ? 3 : exp));
    endtask

    task automatic drive(input logic v, input logic [3:0] opc, input logic [3:0] rs,
                         input logic [3:0] rt, input logic [3:0] rd);
        id_valid = v;
        id_instr = {opc, 12'h000};
        ID_rs    = rs;
        ID_rt    = rt;
        ID_rd    = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        mem_stall    = 1'b0;
        branch_taken = 1'b0;
        drive(1'b0, OPC_HLT, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk_busy("reset_busy", 16'h0000);
        chk_hc("reset_hc", 0);
        rst = 1'b0;

        // Load-to-use: one bubble
        drive(1'b1, OPC_LW, 4'd0, 4'd0, 4'd3);
        chk_ctl("lw_issue", 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, OPC_ADD, 4'd3, 4'd5, 4'd4);
        chk_ctl("lu_stall", 1'b1, 1'b1, 1'b0);
        chk_busy("lu_busy", 16'h0008);
        tick();
        chk_ctl("lu_go", 1'b0, 1'b0, 1'b0);
        chk_hc("lu_hc", 1);
        tick();
        chk_busy("lu_after", 16'h0018);
        drive(1'b0, OPC_HLT, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk_busy("lu_drain", 16'h0000);

        // ALU then taken BR on its rd: two stalls, then flush
        drive(1'b1, OPC_ADD, 4'd0, 4'd0, 4'd2);
        tick();
        branch_taken = 1'b1;
        drive(1'b1, OPC_BR, 4'd2, 4'd0, 4'd0);
        chk_ctl("br_s1", 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("br_s2", 1'b1, 1'b1, 1'b0);
        chk_hc("br_hc1", 2);
        tick();
        chk_ctl("br_go", 1'b0, 1'b0, 1'b1);
        chk_hc("br_hc2", 3);
        tick();
        branch_taken = 1'b0;
        drive(1'b0, OPC_HLT, 4'd0, 4'd0, 4'd0);
        chk_ctl("br_after", 1'b0, 1'b0, 1'b0);

        // Store data tolerates a fresh load; r0 is never tracked
        drive(1'b1, OPC_LW, 4'd0, 4'd0, 4'd7);
        tick();
        drive(1'b1, OPC_SW, 4'd1, 4'd7, 4'd0);
        chk_ctl("sw_data", 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, OPC_LW, 4'd0, 4'd0, 4'd0);
        chk_ctl("lw_r0", 1'b0, 1'b0, 1'b0);
        tick();
        chk_busy("r0_untracked", 16'h0080);
        drive(1'b1, OPC_ADD, 4'd0, 4'd0, 4'd6);
        chk_ctl("add_r0", 1'b0, 1'b0, 1'b0);
        tick();
        chk_busy("add_r0_busy", 16'h0040);
        drive(1'b0, OPC_HLT, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk_hc("sw_hc", 3);

        // Memory freeze holds counters and perf count
        drive(1'b1, OPC_LW, 4'd0, 4'd0, 4'd3);
        tick();
        mem_stall = 1'b1;
        drive(1'b1, OPC_ADD, 4'd3, 4'd0, 4'd4);
        chk_ctl("frz_in", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_ctl("frz", 1'b1, 1'b0, 1'b0);
            chk_busy("frz_busy", 16'h0008);
            chk_hc("frz_hc", 3);
        end
        mem_stall = 1'b0;
        #1;
        chk_ctl("frz_rel", 1'b1, 1'b1, 1'b0);
        tick();
        chk_hc("frz_rel_hc", 4);
        chk_ctl("frz_go", 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, OPC_HLT, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk_busy("frz_drain", 16'h0000);

        // ALU writer overrides a running load countdown
        drive(1'b1, OPC_LW, 4'd0, 4'd0, 4'd5);
        tick();
        drive(1'b0, OPC_HLT, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk_busy("ov_pre", 16'h0020);
        drive(1'b1, OPC_ADD, 4'd0, 4'd0, 4'd5);
        chk_ctl("ov_waw", 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, OPC_BR, 4'd5, 4'd0, 4'd0);
        chk_ctl("ov_s1", 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("ov_s2", 1'b1, 1'b1, 1'b0);
        chk_hc("ov_hc1", 5);
        tick();
        chk_ctl("ov_go", 1'b0, 1'b0, 1'b0);
        chk_hc("ov_hc2", 6);
        tick();
        drive(1'b0, OPC_HLT, 4'd0, 4'd0, 4'd0);

        // Reset in the middle of a stall
        drive(1'b1, OPC_LW, 4'd0, 4'd0, 4'd3);
        tick();
        drive(1'b1, OPC_ADD, 4'd3, 4'd0, 4'd4);
        chk_ctl("pre_rst", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_busy("rst_busy", 16'h0000);
        chk_hc("rst_hc", 0);
        chk_ctl("rst_ctl", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, OPC_HLT, 4'd0, 4'd0, 4'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and stall controller for the 16-bit five-stage pipeline. It replaces fixed stage-by-stage register-ID comparisons with a per-register countdown scoreboard.
- Load-to-use, branch-operand and store-data hazards are resolved from programmable latencies.
- A data-memory stall freezes the scoreboard.
- Taken-branch flush and a saturating hazard-stall performance counter are included.

It sits beside the ID stage and drives the PC/IF-ID hold, the ID/EX bubble and the IF flush.

## Interface
Parameters:
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4]
- REG_W, 4, register-ID width; NUM_REGS = 2**REG_W
- ALU_LAT, 2, countdown loaded when an ALU/LLB/LHB/PCS instruction issues
- LOAD_LAT, 3, countdown loaded when a load (LW) issues
- EX_SLACK, 2, max countdown tolerated by an operand consumed in EX
- MEM_SLACK, 3, max countdown tolerated by store data (rt of SW)
- PERF_W, 16, stall-counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_instr  in  INSTR_W  ID instruction
- ID_rs  in  REG_W  first source (rd for LLB/LHB)
- ID_rt  in  REG_W  second source / store data
- ID_rd  in  REG_W  destination
- mem_stall  in  1  data memory busy, whole pipeline frozen
- branch_taken  in  1  branch resolved taken in ID
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- flush  out  1  squash IF/ID
- busy_mask  out  NUM_REGS  bit r = (cnt[r] != 0)
- hazard_cnt  out  PERF_W  saturating count of bubble cycles

## Operation
Decode by opcode:
- ALU 0000–0111, LLB 1010, LHB 1011 and PCS 1110 write rd.
- LW 1000 writes rd and is a load.
- SW 1001 reads rs as an EX operand and rt as store data (MEM use).
- B 1100 reads no register.
- BR 1101 reads rs in ID, so its required countdown is 0.
- HLT 1111 reads and writes nothing.
- ALU ops read rs and rt in EX; register sources are ignored for opcodes that do not use them.

Scoreboard and hazards:
- Scoreboard: cnt[r] for r = 1..NUM_REGS-1, width clog2(LOAD_LAT+1). Register 0 is never tracked; reads of r0 never hazard and writes to r0 are ignored.
- hazard = id_valid & any used source s with cnt[s] > its slack. Slack is EX_SLACK for EX use, MEM_SLACK for store data and 0 for BR rs.
- stall = hazard, combinational.

Issue and flush:
- issue = id_valid & ~hazard & ~mem_stall.
- On issue of a writer, cnt[ID_rd] loads ALU_LAT, or LOAD_LAT for a load.
- bubble = hazard & ~mem_stall.
- flush = issue & (B | BR) & branch_taken. It is asserted only in the issuing cycle, never while stalled or frozen.

Each cycle with ~mem_stall:
- Every nonzero cnt decrements by 1.
- If the same register is being loaded on issue, the load value wins over the decrement.
- With mem_stall, all counters and hazard_cnt hold.

hazard_cnt increments on bubble and saturates at all-ones.

## Timing
- Reset: all cnt = 0; stall, bubble and flush = 0 combinationally (with id_valid held 0); busy_mask = 0; hazard_cnt = 0. A reset mid-operation clears all of these on the next edge; pending hazards are discarded.
- stall, bubble and flush are combinational from the current inputs and cnt. Counters update on the rising clk edge.

Stall cycles with default parameters:

| Producer issued at edge t | Consumer in ID at t+1 | Stall cycles |
|---|---|---|
| LW | EX-use consumer (cnt 3 > 2) | 1 |
| LW | BR on rd | 3 (issues at t+4) |
| ALU | BR on rd | 2 |
| ALU | EX-use consumer | 0 |
| LW | SW data | 0 |

- mem_stall during a stall extends it 1:1 with no extra bubble count.
- Back-to-back writers to the same rd: the newest latency replaces the old one.

## Structure
- Package hazard_pkg holds:
  - Opcode localparams OPC_LW, OPC_SW, OPC_LLB, OPC_LHB, OPC_B, OPC_BR, OPC_PCS, OPC_HLT.
  - Use-class encoding: USE_NONE, USE_EX, USE_MEM, USE_ID.
  - Function clog2.
- Sub-module hazard_decode is combinational: opcode -> writes_rd, is_load, is_branch, rs_use, rt_use.
- The top level holds the counter array, the hazard compare, and the perf counter.

## Test plan
- LW r3 issues; next ADD r4,r3,r5 -> stall=1 and bubble=1 for exactly 1 cycle, then issue; hazard_cnt=1.
- ADD r2 issues; next BR on r2 with branch_taken=1 -> 2 stall cycles, then flush=1 for 1 cycle; flush=0 during the stall.
- LW r7 then SW with rt=r7, rs=r1 -> no stall; LW r0 then ADD using r0 -> no stall, busy_mask bit0=0.
- LW r3 followed by mem_stall=1 for 4 cycles, then ADD on r3 -> cnt[3] holds at 3 while frozen; exactly 1 bubble after release; hazard_cnt does not change while frozen.
- Overlap on one register:
  - Setup: LW r5; while cnt[5]=1, ADD r5 issues.
  - Required: cnt[5]=2 after the edge, not 0 and not 1.
- Mid-operation reset and saturation:
  - Apply rst mid-stall -> busy_mask=0 and hazard_cnt=0 next cycle.
  - With PERF_W=2, 5 bubbles -> hazard_cnt=3.
